wb_port_scheduler: RTL and testbench
====================================

Name: wb_port_scheduler

Overview:
- Sequences retiring EX/WB results onto the single write port of the 16-entry architectural register file.
- Results are buffered in a small in-order FIFO. A two-destination result (MUL/DIV opcode 247 writing reg0 and reg2) is split into two consecutive writes.
- Push-class stack-pointer decrements and store-completion acknowledgements are also serialised through the same FIFO.
- Decode receives a pending-write scoreboard mask for hazard stalls.
- Sits between the execute stage and the register file, replacing direct multi-port writes.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- NREGS, 16, architectural registers
- XLEN, 64, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  result offered by execute
- in_ready  out  1  FIFO can accept this cycle
- in_kind  in  2  0=single write, 1=dual write, 2=rsp decrement, 3=store ack
- in_dst0  in  4  first destination register
- in_dst1  in  4  second destination register (kind 1 only)
- in_data0  in  XLEN  data for dst0
- in_data1  in  XLEN  data for dst1
- in_sim_end  in  1  entry is the final instruction
- rsp_rdata  in  XLEN  current reg4 value from a regfile read port
- rf_we  out  1  register file write enable
- rf_waddr  out  4  write address
- rf_wdata  out  XLEN  write data
- store_ack  out  1  one-cycle store-completion pulse
- busy_mask  out  NREGS  bit r set: write to r pending
- count  out  $clog2(DEPTH+1)  occupied entries
- sim_end  out  1  one-cycle pulse when final entry retires

Behaviour:
- Reset (synchronous):
  - flushes the FIFO, count=0, drain FSM to IDLE, halted=0.
  - rf_we, store_ack, sim_end and busy_mask are 0 in the cycle after the reset edge.
  - Reset mid-dual-write abandons the second write.
- Push:
  - Occurs on a clk edge with in_valid && in_ready. All in_* fields are captured.
  - in_ready = (count<DEPTH) && !halted. It is registered-state only and never depends on the same-cycle pop.
  - When full, a simultaneous pop does not enable a push that cycle.
- Drain FSM, states IDLE/WR0/WR1; outputs are combinational from head entry and state:
  - IDLE: count==0 → no activity. Otherwise go to WR0 next cycle; first rf_we is one cycle after the accepting edge.
  - WR0, kind 0: rf_we=1, waddr=dst0, wdata=data0; pop; next WR0 if more entries remain (after pop/push), else IDLE.
  - WR0, kind 1: write dst0/data0, no pop, next WR1.
  - WR1: write dst1/data1, pop, then same next-state rule as kind 0.
  - WR0, kind 2: write reg4 with rsp_rdata−8, modulo 2^XLEN (wraps 0→0xFFFF_FFFF_FFFF_FFF8); pop. rsp_rdata is sampled that cycle, so earlier in-order writes have already landed.
  - WR0, kind 3: rf_we=0, store_ack=1 for exactly that cycle; pop.
- Throughput: one write per cycle back-to-back. A dual entry occupies two cycles.
- busy_mask:
  - OR over all occupied entries, including the head, of their destination masks: kind0 dst0; kind1 dst0|dst1; kind2 bit4; kind3 none.
  - Bits clear in the cycle after the owning entry pops, unless another occupied entry also targets that register.
  - A pushed entry's bits appear the cycle after the push edge.
- Dual with dst0==dst1: both writes occur; the final value is data1.
- sim_end: pulses in the cycle the sim_end entry pops, coincident with its last write or ack. halted=1 from the next edge; the FSM then stays in IDLE and pushes are refused until reset.
- count: updated every edge as count + push − pop; range 0..DEPTH.

Test Plan:
- Single push kind0 dst=3 data=0x11 → rf_we=1 with waddr=3, wdata=0x11 exactly one cycle after accept; busy_mask bit3 high one cycle, then 0; count 1→0.
- Kind1 dst0=0 data0=0xA, dst1=2 data1=0xB followed by kind0 dst5 → writes (0,0xA),(2,0xB),(5,x) on three consecutive cycles; mask 0x0005 then 0x0020 drop as each entry pops.
- Kind2 with rsp_rdata=0x1000 → waddr=4, wdata=0x0FF8. Also rsp_rdata=0 → wdata=0xFFFF_FFFF_FFFF_FFF8.
- Push 4 entries while drain is stalled behind a dual → in_ready=0 at count=4; a push attempted while full is dropped, and in_ready is high again the cycle after a pop.
- Kind3 followed by kind0 with sim_end=1 → store_ack one cycle with rf_we=0, then the write with sim_end pulse; in_ready stays 0 afterwards.
- Reset asserted in WR1 of a dual → no dst1 write, count=0, busy_mask=0; the next accepted entry writes normally.

Source files
------------

// File: rtl/wb_port_scheduler.sv
`default_nettype none
// wb_port_scheduler: in-order FIFO that serialises retiring results, dual writes,
// stack-pointer decrements and store acks onto the single register-file write port.
module wb_port_scheduler #(
  parameter int DEPTH = 4,
  parameter int NREGS = 16,
  parameter int XLEN  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_kind,
  input  logic [3:0]                 in_dst0,
  input  logic [3:0]                 in_dst1,
  input  logic [XLEN-1:0]            in_data0,
  input  logic [XLEN-1:0]            in_data1,
  input  logic                       in_sim_end,
  input  logic [XLEN-1:0]            rsp_rdata,
  output logic                       rf_we,
  output logic [3:0]                 rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic                       store_ack,
  output logic [NREGS-1:0]           busy_mask,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       sim_end
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [1:0] KIND_SINGLE = 2'd0;
  localparam logic [1:0] KIND_DUAL   = 2'd1;
  localparam logic [1:0] KIND_RSP    = 2'd2;
  localparam logic [1:0] KIND_STORE  = 2'd3;
  localparam logic [3:0] RSP_REG     = 4'd4;

  typedef enum logic [1:0] {IDLE = 2'd0, WR0 = 2'd1, WR1 = 2'd2} state_t;
  state_t state, state_next;

  logic [1:0]      kind_q [DEPTH];
  logic [3:0]      dst0_q [DEPTH];
  logic [3:0]      dst1_q [DEPTH];
  logic [XLEN-1:0] data0_q[DEPTH];
  logic [XLEN-1:0] data1_q[DEPTH];
  logic            sim_q  [DEPTH];

  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            halted;
  logic            push, pop, fin;
  logic [CW-1:0]   count_next;

  logic [1:0]      h_kind;
  logic [3:0]      h_dst0, h_dst1;
  logic [XLEN-1:0] h_data0, h_data1;
  logic            h_sim;

  assign in_ready = (count < FULL) && !halted;
  assign push     = in_valid && in_ready;

  assign h_kind  = kind_q[rd_ptr];
  assign h_dst0  = dst0_q[rd_ptr];
  assign h_dst1  = dst1_q[rd_ptr];
  assign h_data0 = data0_q[rd_ptr];
  assign h_data1 = data1_q[rd_ptr];
  assign h_sim   = sim_q[rd_ptr];

  always_comb begin
    state_next = state;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    store_ack  = 1'b0;
    pop        = 1'b0;
    case (state)
      WR0: begin
        case (h_kind)
          KIND_SINGLE: begin
            rf_we = 1'b1; rf_waddr = h_dst0; rf_wdata = h_data0; pop = 1'b1;
          end
          KIND_DUAL: begin
            rf_we = 1'b1; rf_waddr = h_dst0; rf_wdata = h_data0;
          end
          KIND_RSP: begin
            rf_we = 1'b1; rf_waddr = RSP_REG; rf_wdata = rsp_rdata - XLEN'(8); pop = 1'b1;
          end
          KIND_STORE: begin
            store_ack = 1'b1; pop = 1'b1;
          end
          default: ;
        endcase
      end
      WR1: begin
        rf_we = 1'b1; rf_waddr = h_dst1; rf_wdata = h_data1; pop = 1'b1;
      end
      default: ;
    endcase

    fin        = pop && h_sim;
    count_next = count + CW'(push) - CW'(pop);

    if (state == WR0 && h_kind == KIND_DUAL)
      state_next = WR1;
    else if (halted || fin)
      state_next = IDLE;
    else
      state_next = (count_next != '0) ? WR0 : IDLE;

    // A write presented while reset is high would land in the regfile; suppress it.
    if (reset) begin
      rf_we     = 1'b0;
      store_ack = 1'b0;
    end
    sim_end = fin && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      halted <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (fin)  halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      kind_q[wr_ptr]  <= in_kind;
      dst0_q[wr_ptr]  <= in_dst0;
      dst1_q[wr_ptr]  <= in_dst1;
      data0_q[wr_ptr] <= in_data0;
      data1_q[wr_ptr] <= in_data1;
      sim_q[wr_ptr]   <= in_sim_end;
    end
  end

  // Slot i is occupied when its distance from the read pointer is below count.
  always_comb begin
    logic [PW-1:0] off;
    busy_mask = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if ({1'b0, off} < count) begin
        case (kind_q[i])
          KIND_SINGLE: busy_mask[dst0_q[i]] = 1'b1;
          KIND_DUAL: begin
            busy_mask[dst0_q[i]] = 1'b1;
            busy_mask[dst1_q[i]] = 1'b1;
          end
          KIND_RSP:   busy_mask[RSP_REG] = 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_scheduler.sv
`default_nettype none
// Bench for wb_port_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_port_scheduler;
  localparam int DEPTH = 4;
  localparam int NREGS = 16;
  localparam int XLEN  = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_kind = '0;
  logic [3:0]       in_dst0 = '0;
  logic [3:0]       in_dst1 = '0;
  logic [XLEN-1:0]  in_data0 = '0;
  logic [XLEN-1:0]  in_data1 = '0;
  logic             in_sim_end = 1'b0;
  logic [XLEN-1:0]  rsp_rdata = '0;
  logic             rf_we;
  logic [3:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             store_ack;
  logic [NREGS-1:0] busy_mask;
  logic [2:0]       count;
  logic             sim_end;

  always #5 clk = ~clk;

  wb_port_scheduler #(.DEPTH(DEPTH), .NREGS(NREGS), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_dst0(in_dst0), .in_dst1(in_dst1),
    .in_data0(in_data0), .in_data1(in_data1), .in_sim_end(in_sim_end),
    .rsp_rdata(rsp_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .store_ack(store_ack), .busy_mask(busy_mask), .count(count), .sim_end(sim_end)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  d0, d1;
    logic [63:0] a0, a1;
    logic        se;
  } ent_t;

  ent_t q[$];
  int   m_done   = 0;   // operations already issued for the head entry
  bit   m_halted = 0;
  bit   armed    = 0;

  always @(negedge clk) begin
    ent_t        h;
    bit          act, last;
    logic        e_we, e_ack, e_se, e_ready;
    logic [3:0]  e_addr;
    logic [63:0] e_data;
    logic [15:0] e_busy;
    act = 0; last = 0;
    e_we = 0; e_ack = 0; e_se = 0; e_addr = '0; e_data = '0; e_busy = '0;
    e_ready = (q.size() < DEPTH) && !m_halted;
    foreach (q[k]) begin
      case (q[k].kind)
        2'd0: e_busy[q[k].d0] = 1'b1;
        2'd1: begin e_busy[q[k].d0] = 1'b1; e_busy[q[k].d1] = 1'b1; end
        2'd2: e_busy[4] = 1'b1;
        default: ;
      endcase
    end
    if (q.size() != 0 && !m_halted) begin
      act = 1;
      h = q[0];
      case (h.kind)
        2'd0: begin e_we = 1; e_addr = h.d0; e_data = h.a0; last = 1; end
        2'd1: begin
          e_we = 1;
          if (m_done == 0) begin e_addr = h.d0; e_data = h.a0; end
          else begin e_addr = h.d1; e_data = h.a1; last = 1; end
        end
        2'd2: begin e_we = 1; e_addr = 4'd4; e_data = rsp_rdata - 64'd8; last = 1; end
        default: begin e_ack = 1; last = 1; end
      endcase
      e_se = last && h.se;
    end
    if (reset) begin e_we = 0; e_ack = 0; e_se = 0; end

    if (armed) begin
      check("model rf_we", rf_we, e_we);
      if (e_we) begin
        check("model rf_waddr", rf_waddr, e_addr);
        check("model rf_wdata", rf_wdata, e_data);
      end
      check("model store_ack", store_ack, e_ack);
      check("model sim_end", sim_end, e_se);
      check("model busy_mask", busy_mask, e_busy);
      check("model count", count, q.size());
      check("model in_ready", in_ready, e_ready);
    end

    if (reset) begin
      q.delete();
      m_done = 0; m_halted = 0; armed = 1;
    end else begin
      if (act) begin
        if (last) begin
          void'(q.pop_front());
          m_done = 0;
          if (h.se) m_halted = 1;
        end else begin
          m_done++;
        end
      end
      if (in_valid && e_ready)
        q.push_back('{kind: in_kind, d0: in_dst0, d1: in_dst1,
                      a0: in_data0, a1: in_data1, se: in_sim_end});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic offer(input logic [1:0] k, input logic [3:0] a, input logic [3:0] b,
                       input logic [63:0] x, input logic [63:0] y, input logic se);
    in_valid = 1'b1; in_kind = k; in_dst0 = a; in_dst1 = b;
    in_data0 = x; in_data1 = y; in_sim_end = se;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_sim_end = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    at_neg();
    check("reset rf_we", rf_we, 0);
    check("reset busy", busy_mask, 0);
    check("reset count", count, 0);
    check("reset ready", in_ready, 1);
    check("reset ack", store_ack, 0);
    check("reset sim_end", sim_end, 0);

    // single write
    offer(2'd0, 4'd3, 4'd0, 64'h11, 64'h0, 1'b0);
    step(); idle();
    at_neg();
    check("single we", rf_we, 1);
    check("single addr", rf_waddr, 3);
    check("single data", rf_wdata, 64'h11);
    check("single busy", busy_mask, 16'h0008);
    check("single count", count, 1);
    step(); at_neg();
    check("single done we", rf_we, 0);
    check("single done busy", busy_mask, 0);
    check("single done count", count, 0);

    // dual followed by single
    offer(2'd1, 4'd0, 4'd2, 64'hA, 64'hB, 1'b0);
    step();
    offer(2'd0, 4'd5, 4'd0, 64'h55, 64'h0, 1'b0);
    at_neg();
    check("dual w0 addr", rf_waddr, 0);
    check("dual w0 data", rf_wdata, 64'hA);
    check("dual w0 busy", busy_mask, 16'h0005);
    step(); idle(); at_neg();
    check("dual w1 addr", rf_waddr, 2);
    check("dual w1 data", rf_wdata, 64'hB);
    check("dual w1 busy", busy_mask, 16'h0025);
    check("dual w1 count", count, 2);
    step(); at_neg();
    check("after dual addr", rf_waddr, 5);
    check("after dual data", rf_wdata, 64'h55);
    check("after dual busy", busy_mask, 16'h0020);
    step(); at_neg();
    check("dual drained we", rf_we, 0);
    check("dual drained busy", busy_mask, 0);

    // stack-pointer decrement, normal and wrapping
    rsp_rdata = 64'h1000;
    offer(2'd2, 4'd0, 4'd0, 64'h0, 64'h0, 1'b0);
    step(); idle(); at_neg();
    check("rsp addr", rf_waddr, 4);
    check("rsp data", rf_wdata, 64'h0FF8);
    check("rsp busy", busy_mask, 16'h0010);
    step();
    rsp_rdata = 64'h0;
    offer(2'd2, 4'd0, 4'd0, 64'h0, 64'h0, 1'b0);
    step(); idle(); at_neg();
    check("rsp wrap data", rf_wdata, 64'hFFFF_FFFF_FFFF_FFF8);
    step();

    // fill behind duals; last dual has dst0==dst1
    for (int i = 0; i < 6; i++) begin
      offer(2'd1, 4'(i), (i == 5) ? 4'd5 : 4'(i + 8), 64'h100 + 64'(i), 64'h200 + 64'(i), 1'b0);
      step();
    end
    offer(2'd0, 4'd15, 4'd0, 64'hDEAD, 64'h0, 1'b0);
    at_neg();
    check("full ready", in_ready, 0);
    check("full count", count, 4);
    step(); idle(); at_neg();
    check("after drop count", count, 3);
    check("after drop ready", in_ready, 1);
    repeat (10) step();

    // reset during the second half of a dual
    offer(2'd1, 4'd10, 4'd11, 64'hA0, 64'hB1, 1'b0);
    step(); idle(); at_neg();
    check("rst dual w0 addr", rf_waddr, 10);
    step();
    reset = 1'b1;
    at_neg();
    check("rst in wr1 we", rf_we, 0);
    step();
    reset = 1'b0;
    at_neg();
    check("post rst count", count, 0);
    check("post rst busy", busy_mask, 0);
    check("post rst we", rf_we, 0);
    offer(2'd0, 4'd12, 4'd0, 64'hC, 64'h0, 1'b0);
    step(); idle(); at_neg();
    check("post rst addr", rf_waddr, 12);
    check("post rst data", rf_wdata, 64'hC);
    step();

    // store ack, then final instruction
    offer(2'd3, 4'd0, 4'd0, 64'h0, 64'h0, 1'b0);
    step();
    offer(2'd0, 4'd13, 4'd0, 64'hD, 64'h0, 1'b1);
    at_neg();
    check("ack pulse", store_ack, 1);
    check("ack we", rf_we, 0);
    check("ack busy", busy_mask, 0);
    step(); idle(); at_neg();
    check("end we", rf_we, 1);
    check("end addr", rf_waddr, 13);
    check("end sim_end", sim_end, 1);
    check("end busy", busy_mask, 16'h2000);
    step();
    offer(2'd0, 4'd14, 4'd0, 64'hE, 64'h0, 1'b0);
    at_neg();
    check("halt ready", in_ready, 0);
    check("halt sim_end", sim_end, 0);
    check("halt we", rf_we, 0);
    repeat (2) step();
    idle(); at_neg();
    check("halt count", count, 0);
    check("halt no write", rf_we, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
